// File: rtl/lfsr_challenge_decoder.sv
// lfsr_challenge_decoder
// Locates an observed 8-bit PUF challenge in the obfuscator LFSR sequence that
// starts at a given seed. The decoder steps its own copy of the LFSR until the
// copy equals the challenge, then reports the number of increments.
// Build option: define LFSR_DEC_BIDIR_EN to also step an inverse LFSR, so the
// sequence is searched in both directions at once. Worst-case latency then
// drops from 255 to 128 cycles.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; results of the last search are held
// SEARCH | one candidate per clock; ends on match, zero lock, exhaustion
//        | or abort
module lfsr_challenge_decoder (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] seed,
    input  logic [7:0] target,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [7:0] step_count,
    output logic       direction
);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

`ifdef LFSR_DEC_BIDIR_EN
    localparam logic [7:0] LAST = 8'd127;
`else
    localparam logic [7:0] LAST = 8'd254;
`endif

    localparam logic [7:0] NOT_FOUND = 8'd255;

    // Forward step of the obfuscator LFSR.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[1] ^ s[2] ^ s[3] ^ s[7]};
    endfunction

`ifdef LFSR_DEC_BIDIR_EN
    // Inverse step: recovers the state that precedes s.
    function automatic logic [7:0] lfsr_inv(input logic [7:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    endfunction
`endif

    state_t     state, state_nxt;
    logic [7:0] fwd, fwd_nxt;
    logic [7:0] idx, idx_nxt;
    logic [7:0] tgt, tgt_nxt;
    // Exactly one of seed/target is zero: the two can never meet, because
    // 0x00 is a fixed point of the LFSR.
    logic       zero_lock, zero_lock_nxt;
    logic       done_r, done_nxt;
    logic       found_r, found_nxt;
    logic [7:0] count_r, count_nxt;
`ifdef LFSR_DEC_BIDIR_EN
    logic [7:0] rev, rev_nxt;
    logic       dir_r, dir_nxt;
`endif

    // Next-state, datapath and result logic for both FSM states.
    always_comb begin
        state_nxt     = state;
        fwd_nxt       = fwd;
        idx_nxt       = idx;
        tgt_nxt       = tgt;
        zero_lock_nxt = zero_lock;
        done_nxt      = 1'b0;
        found_nxt     = found_r;
        count_nxt     = count_r;
`ifdef LFSR_DEC_BIDIR_EN
        rev_nxt       = rev;
        dir_nxt       = dir_r;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = SEARCH;
                    fwd_nxt       = seed;
                    idx_nxt       = 8'd0;
                    tgt_nxt       = target;
                    zero_lock_nxt = (seed == 8'h00) ^ (target == 8'h00);
                    found_nxt     = 1'b0;
                    count_nxt     = 8'd0;
`ifdef LFSR_DEC_BIDIR_EN
                    rev_nxt       = seed;
                    dir_nxt       = 1'b0;
`endif
                end
            end
            SEARCH: begin
                if (abort) begin
                    state_nxt = IDLE;
                    found_nxt = 1'b0;
                    count_nxt = 8'd0;
`ifdef LFSR_DEC_BIDIR_EN
                    dir_nxt   = 1'b0;
`endif
                end else if (fwd == tgt) begin
                    state_nxt = IDLE;
                    found_nxt = 1'b1;
                    count_nxt = idx;
                    done_nxt  = 1'b1;
`ifdef LFSR_DEC_BIDIR_EN
                    dir_nxt   = 1'b0;
                end else if ((idx != 8'd0) && (rev == tgt)) begin
                    state_nxt = IDLE;
                    found_nxt = 1'b1;
                    count_nxt = idx;
                    dir_nxt   = 1'b1;
                    done_nxt  = 1'b1;
`endif
                end else if (zero_lock || (idx == LAST)) begin
                    // Zero lock is decided on the first iteration, so it
                    // shares the give-up path with exhaustion.
                    state_nxt = IDLE;
                    found_nxt = 1'b0;
                    count_nxt = NOT_FOUND;
                    done_nxt  = 1'b1;
                end else begin
                    fwd_nxt = lfsr_step(fwd);
                    idx_nxt = idx + 8'd1;
`ifdef LFSR_DEC_BIDIR_EN
                    rev_nxt = lfsr_inv(rev);
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, search datapath and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fwd       <= 8'd0;
            idx       <= 8'd0;
            tgt       <= 8'd0;
            zero_lock <= 1'b0;
            done_r    <= 1'b0;
            found_r   <= 1'b0;
            count_r   <= 8'd0;
`ifdef LFSR_DEC_BIDIR_EN
            rev       <= 8'd0;
            dir_r     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            fwd       <= fwd_nxt;
            idx       <= idx_nxt;
            tgt       <= tgt_nxt;
            zero_lock <= zero_lock_nxt;
            done_r    <= done_nxt;
            found_r   <= found_nxt;
            count_r   <= count_nxt;
`ifdef LFSR_DEC_BIDIR_EN
            rev       <= rev_nxt;
            dir_r     <= dir_nxt;
`endif
        end
    end

    assign busy       = (state == SEARCH);
    assign done       = done_r;
    assign found      = found_r;
    assign step_count = count_r;
`ifdef LFSR_DEC_BIDIR_EN
    assign direction  = dir_r;
`else
    assign direction  = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_challenge_decoder.sv
// Self-checking bench for lfsr_challenge_decoder: directed vector table,
// hand-written abort/reset sequences and randomized searches checked against
// an orbit-distance model. Follows LFSR_DEC_BIDIR_EN like the design.
module tb_lfsr_challenge_decoder;

    logic       clock;
    logic       reset_n;
    logic [7:0] seed;
    logic [7:0] target;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       found;
    logic [7:0] step_count;
    logic       direction;

    int passed = 0;
    int total  = 0;

    lfsr_challenge_decoder dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .seed       (seed),
        .target     (target),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .step_count (step_count),
        .direction  (direction)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

`ifdef LFSR_DEC_BIDIR_EN
    localparam bit BIDIR = 1'b1;
    localparam int LAST  = 127;
`else
    localparam bit BIDIR = 1'b0;
    localparam int LAST  = 254;
`endif

    typedef struct {
        logic [7:0] s;
        logic [7:0] t;
        logic       ab;
        logic       f;
        int         c;
        logic       d;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] mstep(input logic [7:0] s);
        return {s[6:0], s[1] ^ s[2] ^ s[3] ^ s[7]};
    endfunction

    // Position of t in the sequence starting at s, or -1 if never reached.
    function automatic int fwd_dist(input logic [7:0] s, input logic [7:0] t);
        logic [7:0] x;
        x = s;
        for (int k = 0; k < 255; k++) begin
            if (x == t) return k;
            x = mstep(x);
        end
        return -1;
    endfunction

    // Expected result from orbit distances: first hit wins, forward on ties.
    task automatic model(input logic [7:0] s, input logic [7:0] t,
                         output logic f, output int c, output logic d,
                         output int lat);
        int df, dr;
        f = 1'b0; c = 255; d = 1'b0; lat = LAST + 1;
        if (s == t) begin
            f = 1'b1; c = 0; lat = 1;
        end else if ((s == 8'h00) != (t == 8'h00)) begin
            lat = 1;
        end else begin
            df = fwd_dist(s, t);
            dr = (df > 0) ? 255 - df : 1000;
            if (!BIDIR) dr = 1000;
            if (df >= 0 && df <= LAST && df <= dr) begin
                f = 1'b1; c = df; lat = df + 1;
            end else if (dr <= LAST) begin
                f = 1'b1; c = dr; d = 1'b1; lat = dr + 1;
            end
        end
    endtask

    // Target at least 10 steps away from 0x01 in both directions.
    function automatic logic [7:0] far_target();
        int df;
        if (!BIDIR) return 8'h80;
        for (int k = 1; k < 256; k++) begin
            df = fwd_dist(8'h01, 8'(k));
            if (df >= 10 && (255 - df) >= 10) return 8'(k);
        end
        return 8'h80;
    endfunction

    // Runs one search from #1 after a clock edge and checks the outcome.
    task automatic run_search(input string name, input logic [7:0] s,
                              input logic [7:0] t, input logic ab,
                              input logic ef, input int ec, input logic ed,
                              input int elat);
        int lat;
        seed = s; target = t; start = 1'b1; abort = ab;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        check({name, "_busy_start"}, busy, 1);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!done && lat < 300);
        check({name, "_done"}, done, 1);
        check({name, "_latency"}, lat, elat);
        check({name, "_found"}, found, ef);
        check({name, "_count"}, step_count, ec);
        check({name, "_dir"}, direction, ed);
        check({name, "_busy_end"}, busy, 0);
        @(posedge clock); #1;
        check({name, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        logic [7:0] s, t, far;
        logic       ef, ed;
        int         ec, elat, ndone, nlow;

        vecs.push_back('{8'h01, 8'h0B, 1'b0, 1'b1, 3,   1'b0, 4});
        vecs.push_back('{8'hA5, 8'hA5, 1'b0, 1'b1, 0,   1'b0, 1});
        vecs.push_back('{8'h00, 8'h01, 1'b0, 1'b0, 255, 1'b0, 1});
        vecs.push_back('{8'h01, 8'h00, 1'b0, 1'b0, 255, 1'b0, 1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 0,   1'b0, 1});
        vecs.push_back('{8'h01, 8'h0B, 1'b1, 1'b1, 3,   1'b0, 4});
`ifdef LFSR_DEC_BIDIR_EN
        vecs.push_back('{8'h0B, 8'h01, 1'b0, 1'b1, 3,   1'b1, 4});
`else
        vecs.push_back('{8'h0B, 8'h01, 1'b0, 1'b1, 252, 1'b0, 253});
`endif

        reset_n = 1'b0; seed = 8'h00; target = 8'h00; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_count", step_count, 0);
        check("rst_dir", direction, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[k])
            run_search($sformatf("vec%0d", k), vecs[k].s, vecs[k].t, vecs[k].ab,
                       vecs[k].f, vecs[k].c, vecs[k].d, vecs[k].lat);

        // Abort with an ignored mid-search start.
        far = far_target();
        seed = 8'h01; target = far; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ndone = 0; nlow = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clock); #1;
            if (cyc <= 5) begin
                if (done) ndone++;
                if (!busy) nlow++;
            end
            if (cyc == 2) begin
                seed = 8'hA5; target = 8'hA5; start = 1'b1;
            end
            if (cyc == 3) start = 1'b0;
            if (cyc == 5) abort = 1'b1;
            if (cyc == 6) abort = 1'b0;
        end
        check("abort_busy_held", nlow, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_found", found, 0);
        check("abort_count", step_count, 0);
        repeat (3) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_search("after_abort", 8'h01, 8'h0B, 1'b0, 1'b1, 3, 1'b0, 4);

        // Reset in the middle of a search.
        seed = 8'h01; target = far; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_found", found, 0);
        check("midrst_count", step_count, 0);
        check("midrst_dir", direction, 0);
        ndone = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);

        // Randomized searches against the orbit model.
        for (int k = 0; k < 30; k++) begin
            s = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            if (k % 7 == 3) s = 8'h00;
            if (k % 11 == 5) t = 8'h00;
            if (k % 9 == 4) t = s;
            model(s, t, ef, ec, ed, elat);
            run_search($sformatf("rnd%0d_%02h_%02h", k, s, t), s, t, 1'b0,
                       ef, ec, ed, elat);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lfsr_challenge_decoder.md
# lfsr_challenge_decoder

Recovers the step index of an 8-bit PUF challenge produced by the serial-PUF challenge obfuscator LFSR. Given the seed loaded into the obfuscator and an observed challenge, it steps its own copy of the same LFSR until it matches and reports how many increments separate the two. It sits on the verification/enrolment side of the serial PUF: it maps captured challenge/response pairs back to their position in the challenge sequence.

## Interface
Parameters: none. The polynomial and width are fixed to match the obfuscator.
- clock  input  1  rising-edge system clock
- reset_n  input  1  asynchronous, active-low reset; single clock domain
- seed  input  8  LFSR seed; sampled only on an accepted start
- target  input  8  challenge to locate; sampled only on an accepted start
- start  input  1  begin a search; accepted only when busy=0
- abort  input  1  cancel a search in progress
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse when a search completes (not raised on abort)
- found  output  1  1 = target reached; held until the next accepted start
- step_count  output  8  number of increments from seed to target; held until the next accepted start
- direction  output  1  0 = forward distance, 1 = reverse distance; held until the next accepted start

## Operation
- Step function (identical to the obfuscator): nb = s[1]^s[2]^s[3]^s[7]; next = {s[6:0], nb}. The period is 255 over nonzero states; 0x00 locks up.
- Inverse step (used only with BIDIR): prev = {s[0]^s[2]^s[3]^s[4], s[7:1]}.
- FSM states: IDLE and SEARCH.
- IDLE:
  - start=1 latches seed and target, sets fwd<=seed, rev<=seed, i<=0, and clears found, step_count and direction.
  - The next state is SEARCH.
- SEARCH, evaluated once per clock at iteration i:
  - (1) abort=1: go to IDLE. No done pulse. found=0, step_count=0.
  - (2) fwd==target: found<=1, step_count<=i, direction<=0, done<=1, go to IDLE.
  - (3) BIDIR only, i>=1 and rev==target: found<=1, step_count<=i, direction<=1, done<=1, go to IDLE.
  - (4) Zero lock: exactly one of seed and target is 0x00. Then found<=0, step_count<=255, done<=1, go to IDLE at i=0.
  - (5) i==LAST: found<=0, step_count<=255, done<=1, go to IDLE. LAST is 254, or 127 with BIDIR.
  - Otherwise: fwd<=step(fwd), rev<=inv(rev) (BIDIR only), i<=i+1.
- Priority order is abort > forward match > reverse match > zero lock > exhaustion.
- start is ignored while busy=1.
- start and abort asserted together in IDLE: start wins, and abort is ignored.
- i is an 8-bit counter that never wraps, because exhaustion fires first.

## Timing
- Reset values: busy=0, done=0, found=0, step_count=0x00, direction=0. The FSM is in IDLE with fwd, rev and i all zero.
- reset_n asserted mid-search aborts immediately; no done pulse follows.
- Let E0 be the edge that accepts start. busy is high from E0 until the completion edge.
- A match at iteration k sets done at edge E(k+1), so latency is k+1 cycles.
  - Worst case is 255 cycles, or 128 with BIDIR.
  - seed==target: done and found rise 1 cycle after start.
- done is high for exactly one cycle. busy falls on the same edge that raises done.
- A new start may be accepted on the cycle done is high, because busy is already 0.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- LFSR_DEC_BIDIR_EN defined:
  - The rev register and the inverse-step search are instantiated.
  - The search runs forward and backward in parallel.
  - LAST=127, and direction can be 1.
- LFSR_DEC_BIDIR_EN undefined:
  - Forward search only, with LAST=254.
  - The direction port still exists and is tied to 0.
  - No rev logic is present.

## Test plan
- Reset mid-search: after reset_n rises, all outputs are 0 and busy=0. No done pulse occurs.
- seed=0x01, target=0x0B, start (forward path 0x01→0x02→0x05→0x0B) -> done 4 cycles after start, found=1, step_count=3, direction=0.
- seed=0xA5, target=0xA5 -> done 1 cycle after start, found=1, step_count=0.
- seed=0x00, target=0x01 -> done 1 cycle after start, found=0, step_count=255. Repeat with seed=0x01, target=0x00 and expect the same response.
- seed=0x0B, target=0x01:
  - Macro off: done 253 cycles after start, found=1, step_count=252, direction=0.
  - Macro on: done 4 cycles after start, found=1, step_count=3, direction=1.
- Abort and start while busy: seed=0x01, target=0x00 is not usable here, so use seed=0x01, target=0x80.
  - Pulse start again at cycle 2; it must be ignored.
  - Pulse abort at cycle 5 -> busy=0 next cycle, no done pulse, found=0, step_count=0.
  - A fresh start then completes normally.
